event_flag_drainer: RTL and testbench
=====================================

// Module: event_flag_drainer
// PURPOSE
//   Consumer side of the team's sticky set/clear flags. Captures one-cycle event strobes from N producers
//   into per-event pending flags and drains them one at a time through a valid/ready port.
//   A drained flag clears on acceptance. Sits between datapath done/error pulses and the sequencing controller.
// PARAMETERS
//   NUM_EVENTS  8                    number of event sources (>=2)
//   IDX_W       $clog2(NUM_EVENTS)   width of event index (derived, do not override)
// PORTS
//   clk        in   1           clock, all logic on rising edge
//   rst        in   1           asynchronous reset, active-low (asserted when 0)
//   evt_set    in   NUM_EVENTS  one-cycle set strobes, one bit per source
//   evt_valid  out  1           an event index is offered
//   evt_idx    out  IDX_W       index of offered event
//   evt_ready  in   1           consumer accepts offered index
//   pending    out  NUM_EVENTS  current pending flags (registered)
//   overflow   out  NUM_EVENTS  sticky: set while already pending (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=0, async): pending=0, overflow=0, evt_valid=0, evt_idx=0, rr_ptr=0, state=IDLE.
//   Flags: pending[i] <= evt_set[i] | (pending[i] & ~clr[i]); clr[i]=evt_valid & evt_ready & evt_idx==i.
//     Set wins over clear in the same cycle: flag stays 1, event is offered again later.
//   FSM states: IDLE, OFFER.
//     IDLE: if |pending: pick first set bit at or after rr_ptr (wrap NUM_EVENTS-1 -> 0),
//       register evt_idx, evt_valid<=1, go OFFER. Else stay, evt_valid=0.
//     OFFER: evt_valid=1; evt_idx held stable until handshake. On evt_valid&evt_ready:
//       evt_valid<=0, rr_ptr<=evt_idx+1 (wrap to 0 at NUM_EVENTS), go IDLE.
//   Selection uses pending register only (not same-cycle evt_set).
//   Latency: strobe at edge t -> pending at t+1 -> evt_valid at t+2 (if IDLE, no older pending).
//   Throughput: at most one accept every 2 cycles (IDLE cycle between offers).
//   evt_ready while evt_valid=0 is ignored. evt_valid never drops without handshake.
//   All pending set simultaneously: served strictly round-robin, no source starved.
//   Reset mid-offer: offer aborted, every pending flag lost, no accept reported.
// CONFIGURATION
//   Macro EVENT_FLAG_OVERFLOW_EN.
//   Defined: overflow[i] <= 1 when evt_set[i]=1 and pending[i]=1 and clr[i]=0.
//     Sticky until reset. Set+clear in same cycle is not overflow.
//   Undefined: overflow port tied to '0, no overflow flops generated.
// STRUCTURE
//   Package event_flag_pkg: typedef enum logic {IDLE, OFFER} drain_state_t; MAX_EVENTS=32 guard constant.
//   Sub-module rr_priority_pick (combinational): inputs req[N], ptr[IDX_W]; outputs found, idx[IDX_W].
//   Top holds flags, FSM, rr_ptr and overflow logic.
// TESTING
//   1 evt_set=8'h04 one cycle, evt_ready=1 -> evt_valid at t+2, evt_idx=2; pending=0 after accept.
//   2 evt_set=8'hFF one cycle, evt_ready=1 -> idx order 0..7, one accept per 2 cycles, then evt_valid=0.
//   3 pending=8'h01, evt_ready=0 for 5 cycles -> evt_valid=1, evt_idx=0 stable; accept on cycle 6 clears.
//   4 evt_set[3] in the accept cycle of idx 3 -> pending[3] stays 1, idx 3 re-offered; overflow[3]=0.
//   5 (EVENT_FLAG_OVERFLOW_EN) evt_set[5] twice while unaccepted -> overflow=8'h20, held after accept.
//   6 rst=0 asynchronously during OFFER -> evt_valid, pending, overflow all 0 at once, before any clk edge.

Source files
------------

// File: rtl/event_flag_pkg.sv
// Shared types and constants for the event flag drainer.
// Optional feature macro used by the top: EVENT_FLAG_OVERFLOW_EN.
package event_flag_pkg;

    // Drain controller states: IDLE picks the next pending flag, OFFER holds it until accepted.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } drain_state_t;

    // Upper bound on the number of event sources this block is intended for.
    localparam int MAX_EVENTS = 32;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: returns the first set request bit at or after ptr,
// wrapping from N-1 back to 0.
module rr_priority_pick #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the farthest offset down to offset 0 so the nearest request wins last.
    always_comb begin
        int w_j;
        found = 1'b0;
        idx   = '0;
        w_j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = int'(ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (req[w_j]) begin
                found = 1'b1;
                idx   = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/event_flag_drainer.sv
// Captures one-cycle event strobes into sticky pending flags and drains them one at a
// time, round-robin, through a valid/ready port. A flag clears when its index is accepted.
// Optional macro EVENT_FLAG_OVERFLOW_EN adds sticky per-event overflow flags.
module event_flag_drainer
    import event_flag_pkg::*;
#(
    parameter  int NUM_EVENTS = 8,
    localparam int IDX_W      = $clog2(NUM_EVENTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] evt_set,
    output logic                  evt_valid,
    output logic [IDX_W-1:0]      evt_idx,
    input  logic                  evt_ready,
    output logic [NUM_EVENTS-1:0] pending,
    output logic [NUM_EVENTS-1:0] overflow
);

    drain_state_t          r_state;
    logic                  r_evt_valid;
    logic [IDX_W-1:0]      r_evt_idx;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [NUM_EVENTS-1:0] r_pending;
    logic [NUM_EVENTS-1:0] w_clr;
    logic                  w_accept;
    logic                  w_found;
    logic [IDX_W-1:0]      w_pick_idx;

    assign w_accept  = r_evt_valid & evt_ready;
    assign evt_valid = r_evt_valid;
    assign evt_idx   = r_evt_idx;
    assign pending   = r_pending;

    // Selection looks only at the registered flags, never at same-cycle strobes.
    rr_priority_pick #(
        .N     (NUM_EVENTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (r_pending),
        .ptr   (r_rr_ptr),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_flag
            assign w_clr[gi] = w_accept & (r_evt_idx == IDX_W'(gi));

            // Per-source sticky flag; a new strobe beats a same-cycle clear.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_pending[gi] <= 1'b0;
                end else begin
                    r_pending[gi] <= evt_set[gi] | (r_pending[gi] & ~w_clr[gi]);
                end
            end
        end
    endgenerate

`ifdef EVENT_FLAG_OVERFLOW_EN
    logic [NUM_EVENTS-1:0] r_overflow;
    assign overflow = r_overflow;

    generate
        for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_ovf
            // Latch a strobe that lands on an already-pending, not-being-cleared flag.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_overflow[gi] <= 1'b0;
                end else if (evt_set[gi] & r_pending[gi] & ~w_clr[gi]) begin
                    r_overflow[gi] <= 1'b1;
                end
            end
        end
    endgenerate
`else
    assign overflow = '0;
`endif

    // Drain FSM: pick in IDLE, hold the offer stable in OFFER until the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_evt_valid <= 1'b0;
            r_evt_idx   <= '0;
            r_rr_ptr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_evt_idx   <= w_pick_idx;
                        r_evt_valid <= 1'b1;
                        r_state     <= OFFER;
                    end else begin
                        r_evt_valid <= 1'b0;
                    end
                end
                OFFER: begin
                    r_evt_valid <= 1'b1;
                    if (evt_ready) begin
                        r_evt_valid <= 1'b0;
                        r_state     <= IDLE;
                        if (r_evt_idx == IDX_W'(NUM_EVENTS - 1)) begin
                            r_rr_ptr <= '0;
                        end else begin
                            r_rr_ptr <= r_evt_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_evt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_flag_drainer.sv
// Directed testbench for event_flag_drainer (8 events). Outputs are sampled 1 time unit
// after each rising edge; inputs change at the same point so they are stable at the next edge.
module tb_event_flag_drainer;

    logic       clk;
    logic       rst;
    logic [7:0] evt_set;
    logic       evt_valid;
    logic [2:0] evt_idx;
    logic       evt_ready;
    logic [7:0] pending;
    logic [7:0] overflow;

    int total;
    int bad;

    event_flag_drainer #(.NUM_EVENTS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .evt_set   (evt_set),
        .evt_valid (evt_valid),
        .evt_idx   (evt_idx),
        .evt_ready (evt_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_pend;
        logic [7:0] exp_ovf;
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        evt_set   = 8'h00;
        evt_ready = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_valid",    32'(evt_valid), 32'h0);
        chk("rst_idx",      32'(evt_idx),   32'h0);
        chk("rst_pending",  32'(pending),   32'h0);
        chk("rst_overflow", 32'(overflow),  32'h0);
        rst = 1'b1;
        tick();
        $display("txn reset done");

        // 1: single strobe on source 2
        evt_set   = 8'h04;
        evt_ready = 1'b1;
        tick();
        evt_set = 8'h00;
        chk("t1_pend_t1",  32'(pending),   32'h04);
        chk("t1_valid_t1", 32'(evt_valid), 32'h0);
        tick();
        chk("t1_valid_t2", 32'(evt_valid), 32'h1);
        chk("t1_idx_t2",   32'(evt_idx),   32'h2);
        tick();
        chk("t1_valid_acc", 32'(evt_valid), 32'h0);
        chk("t1_pend_acc",  32'(pending),   32'h00);
        $display("txn t1 single strobe idx=2 accepted");

        // 2: all sources at once, served 0..7 from a fresh pointer
        evt_ready = 1'b0;
        do_reset();
        evt_set   = 8'hFF;
        evt_ready = 1'b1;
        tick();
        evt_set = 8'h00;
        chk("t2_pend_init", 32'(pending),   32'hFF);
        chk("t2_valid_init", 32'(evt_valid), 32'h0);
        exp_pend = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_valid_offer", 32'(evt_valid), 32'h1);
            chk("t2_idx_offer",   32'(evt_idx),   32'(k));
            tick();
            exp_pend[k] = 1'b0;
            chk("t2_valid_gap", 32'(evt_valid), 32'h0);
            chk("t2_pend_gap",  32'(pending),   32'(exp_pend));
            $display("txn t2 accept idx=%0d pending=%02h", k, exp_pend);
        end
        tick();
        chk("t2_valid_end", 32'(evt_valid), 32'h0);

        // 3: held offer under backpressure
        evt_ready = 1'b0;
        evt_set   = 8'h01;
        tick();
        evt_set = 8'h00;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t3_valid_hold", 32'(evt_valid), 32'h1);
            chk("t3_idx_hold",   32'(evt_idx),   32'h0);
            chk("t3_pend_hold",  32'(pending),   32'h01);
            tick();
        end
        evt_ready = 1'b1;
        tick();
        chk("t3_valid_acc", 32'(evt_valid), 32'h0);
        chk("t3_pend_acc",  32'(pending),   32'h00);
        evt_ready = 1'b0;
        $display("txn t3 held offer idx=0 accepted after stall");

        // 4: re-strobe in the accept cycle of the same index
        evt_set = 8'h08;
        tick();
        evt_set = 8'h00;
        tick();
        chk("t4_valid", 32'(evt_valid), 32'h1);
        chk("t4_idx",   32'(evt_idx),   32'h3);
        evt_set   = 8'h08;
        evt_ready = 1'b1;
        tick();
        evt_set = 8'h00;
        chk("t4_valid_acc", 32'(evt_valid), 32'h0);
        chk("t4_pend_kept", 32'(pending),   32'h08);
        chk("t4_ovf",       32'(overflow),  32'h00);
        tick();
        chk("t4_valid_re", 32'(evt_valid), 32'h1);
        chk("t4_idx_re",   32'(evt_idx),   32'h3);
        tick();
        chk("t4_pend_end", 32'(pending), 32'h00);
        evt_ready = 1'b0;
        $display("txn t4 set-wins-clear idx=3 re-offered");

        // 5: double strobe while unaccepted
`ifdef EVENT_FLAG_OVERFLOW_EN
        exp_ovf = 8'h20;
`else
        exp_ovf = 8'h00;
`endif
        evt_set = 8'h20;
        tick();
        chk("t5_ovf_first", 32'(overflow), 32'h00);
        evt_set = 8'h20;
        tick();
        evt_set = 8'h00;
        chk("t5_ovf_second", 32'(overflow),  32'(exp_ovf));
        chk("t5_valid",      32'(evt_valid), 32'h1);
        chk("t5_idx",        32'(evt_idx),   32'h5);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("t5_pend_acc", 32'(pending),  32'h00);
        chk("t5_ovf_held", 32'(overflow), 32'(exp_ovf));
        $display("txn t5 double strobe idx=5 overflow=%02h", exp_ovf);

        // 6: asynchronous reset during an offer
        evt_set = 8'h60;
        tick();
        evt_set = 8'h20;
        tick();
        evt_set = 8'h00;
        chk("t6_valid_pre", 32'(evt_valid), 32'h1);
        chk("t6_pend_pre",  32'(pending),   32'h60);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_valid_rst", 32'(evt_valid), 32'h0);
        chk("t6_pend_rst",  32'(pending),   32'h00);
        chk("t6_ovf_rst",   32'(overflow),  32'h00);
        chk("t6_idx_rst",   32'(evt_idx),   32'h0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("t6_valid_after", 32'(evt_valid), 32'h0);
        $display("txn t6 async reset mid-offer");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
